// File: rtl/out_port_sched.sv
// out_port_sched: round-robin scheduler driving the out_port buffer select.
// Grants one eligible buffer at a time, holds i_addr until downstream accepts
// the word (valid_next low), counts accepted transfers and flags stalls that
// exceed TIMEOUT wait cycles.
module out_port_sched #(
  parameter int unsigned NPORT   = 3,  // at most 3; i_addr 2'b11 means idle
  parameter int unsigned TIMEOUT = 15  // 1..255
) (
  input  logic             gclock,
  input  logic             reset,        // synchronous, active-low
  input  logic             enable,
  input  logic [NPORT-1:0] port_pending,
  input  logic [NPORT-1:0] port_mask,
  input  logic             valid_next,   // 0 = word accepted this cycle
  output logic [1:0]       i_addr,
  output logic [1:0]       grant_port,
  output logic             xfer_done,
  output logic [15:0]      xfer_count,
  output logic             stall_err
);

  localparam logic [1:0] AddrIdle = 2'b11;
  localparam logic [1:0] LastPort = 2'(NPORT - 1);
  localparam logic [7:0] WdLimit  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      r_state;
  logic [1:0]  r_i_addr;
  logic [1:0]  r_grant_port;
  logic [1:0]  r_ptr;
  logic        r_xfer_done;
  logic [15:0] r_xfer_count;
  logic        r_stall_err;
  logic [7:0]  r_wd;

  logic [NPORT-1:0] w_eligible;
  logic [3:0]       w_elig_pad;
  logic [2:0]       w_sum;
  logic             w_found;
  logic [1:0]       w_winner;

  // Round-robin search starting just after the pointer, ending at the pointer.
  always_comb begin
    w_eligible = port_pending & ~port_mask;
    w_elig_pad = 4'(w_eligible);
    w_found    = 1'b0;
    w_winner   = r_ptr;
    w_sum      = 3'd0;
    for (int i = 1; i <= int'(NPORT); i++) begin
      w_sum = {1'b0, r_ptr} + 3'(i);
      if (w_sum >= 3'(NPORT)) begin
        w_sum = w_sum - 3'(NPORT);
      end
      if (!w_found && w_elig_pad[w_sum[1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[1:0];
      end
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge gclock) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_i_addr     <= AddrIdle;
      r_grant_port <= LastPort;
      r_ptr        <= LastPort;
      r_xfer_done  <= 1'b0;
      r_xfer_count <= 16'd0;
      r_stall_err  <= 1'b0;
      r_wd         <= 8'd0;
    end else begin
      r_xfer_done <= 1'b0;
      case (r_state)
        StIdle: begin
          r_i_addr <= AddrIdle;
          if (enable && w_found) begin
            r_i_addr     <= w_winner;
            r_ptr        <= w_winner;
            r_grant_port <= w_winner;
            r_state      <= StIssue;
          end
        end
        StIssue: begin
          // One cycle for out_port to latch the address before watching valid_next.
          r_wd    <= 8'd0;
          r_state <= StWait;
        end
        StWait: begin
          if (!valid_next) begin
            r_xfer_done  <= 1'b1;
            r_xfer_count <= r_xfer_count + 16'd1;
            // Re-arbitrate on the accepting edge so transfers run back-to-back.
            if (enable && w_found) begin
              r_i_addr     <= w_winner;
              r_ptr        <= w_winner;
              r_grant_port <= w_winner;
              r_state      <= StIssue;
            end else begin
              r_i_addr <= AddrIdle;
              r_state  <= StIdle;
            end
          end else if (r_wd == WdLimit) begin
            // Abandon the stalled transfer; pointer stays on it so others go first.
            r_wd        <= r_wd + 8'd1;
            r_stall_err <= 1'b1;
            r_i_addr    <= AddrIdle;
            r_state     <= StIdle;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        default: begin
          r_i_addr <= AddrIdle;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  assign i_addr     = r_i_addr;
  assign grant_port = r_grant_port;
  assign xfer_done  = r_xfer_done;
  assign xfer_count = r_xfer_count;
  assign stall_err  = r_stall_err;

endmodule

// File: doc/out_port_sched.md
Name: out_port_sched

Overview:
- Scheduler that drives the interconnect-side buffer select (i_addr) of an out_port instance.
- Picks among the three core-side buffers that hold undelivered data, using round-robin.
- Holds each selection until the downstream block accepts the word, then moves on.
- Sits between the out_port and the CCM. It replaces ad-hoc i_addr sequencing, adds fairness and a stall watchdog, and keeps a transfer count.

Parameters:
- NPORT, 3, number of logical buffers; i_addr code 2'b11 is reserved for idle, so NPORT is at most 3.
- TIMEOUT, 15, WAIT cycles with valid_next high before the transfer is abandoned; range 1..255.

Ports:
- gclock  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-low.
- enable  in  1  1 = scheduling allowed; 0 = finish the current transfer, then idle.
- port_pending  in  NPORT  bit k = buffer k holds data awaiting transfer.
- port_mask  in  NPORT  bit k = 1 excludes buffer k from arbitration.
- valid_next  in  1  downstream flow control; 0 = word accepted this cycle, 1 = downstream busy.
- i_addr  out  2  buffer select to out_port; 2'b11 = no data.
- grant_port  out  2  last granted buffer index, for debug.
- xfer_done  out  1  one-cycle pulse per accepted transfer.
- xfer_count  out  16  total accepted transfers.
- stall_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset==0 at a rising edge), all registered:
  - i_addr=2'b11, grant_port=NPORT-1, xfer_done=0, xfer_count=0, stall_err=0.
  - FSM=IDLE, round-robin pointer=NPORT-1 (so port 0 wins first), watchdog=0.
  - Reset overrides everything, including mid-transfer; the transfer in progress is dropped and not counted.
- Eligible set: port_pending & ~port_mask. Eligibility is sampled only when a grant is made.
- Round-robin order: search from pointer+1, wrapping modulo NPORT, ending at pointer. The first eligible index wins. On grant, pointer=winner and grant_port=winner.
- State IDLE:
  - i_addr=2'b11.
  - If enable and eligible set non-empty at an edge: i_addr<=winner, go to ISSUE.
- State ISSUE (exactly 1 cycle):
  - i_addr held. This gives out_port one cycle to latch the address and present data_out.
  - Watchdog cleared. Go to WAIT.
- State WAIT:
  - i_addr held.
  - If valid_next==0 at an edge, the transfer is accepted:
    - xfer_done<=1 for one cycle; xfer_count<=xfer_count+1, wrapping 16'hFFFF->0.
    - In the same edge, re-arbitrate. If enable and eligible non-empty: i_addr<=new winner, go to ISSUE (back-to-back). Otherwise i_addr<=2'b11, go to IDLE.
  - If valid_next==1: watchdog increments. When it reaches TIMEOUT:
    - stall_err<=1 (sticky until reset), i_addr<=2'b11, go to IDLE.
    - No xfer_done, no count. The pointer keeps the stalled port, so other ports get priority next.
- Minimum grant-to-accept latency: 2 edges (ISSUE, then WAIT with valid_next=0). Steady-state throughput is one transfer per 2 cycles.
- enable dropping during ISSUE/WAIT: the current transfer completes or times out normally; no new grant follows.
- Changes to port_pending or port_mask during ISSUE/WAIT are ignored for the active transfer.
- A single eligible port is re-granted repeatedly. With all ports eligible, the grant order is 0,1,2,0,…
- xfer_done is 0 in every cycle except the one after an accepting edge.

Test Plan:
- Reset: hold reset=0 for 3 edges with random inputs -> i_addr=3, xfer_count=0, stall_err=0, xfer_done=0. Assert reset=0 in WAIT -> i_addr=3 next cycle, count unchanged.
- Single request: port_pending=3'b010, valid_next=0, enable=1 -> i_addr=1 one edge after sampling. xfer_done pulses 2 edges after grant; count=1; port 1 re-granted while pending stays 1.
- Fairness: port_pending=3'b111 held, valid_next=0 -> grant sequence 0,1,2,0,1,2. After 6 accepts xfer_count=6; no port is granted twice before the others.
- Backpressure: one port pending, valid_next=1 for 5 WAIT cycles then 0 -> i_addr stable throughout, exactly one xfer_done, stall_err=0.
- Watchdog: valid_next held 1, TIMEOUT=15 -> after 15 WAIT cycles stall_err=1, i_addr=3, count unchanged. stall_err stays 1 after valid_next drops and new transfers complete.
- Mask/enable: port_pending=3'b111, port_mask=3'b101 -> only port 1 granted. Drop enable mid-WAIT -> that transfer completes, then i_addr=3 with no further grants.
